// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

   typedef enum logic [0:0] {
      RUN    = 1'b0,
      HALTED = 1'b1
   } fetch_state_t;

   localparam int INSTR_BYTES    = 4;
   localparam int FETCH_PC_MAX_W = 32;

   // The pc field is sized for the widest supported PC; narrower builds zero-extend.
   typedef struct packed {
      logic [31:0]               instr;
      logic [FETCH_PC_MAX_W-1:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO with push/pop/flush, occupancy count and a registered head entry.
module fetch_buffer
   import fetch_pkg::*;
#(
   parameter int  DEPTH   = 2,
   parameter type entry_t = fetch_entry_t,
   parameter int  CW      = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  entry_t        push_data,
   output entry_t        head,
   output logic [CW-1:0] count
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   entry_t        mem_q [DEPTH];
   entry_t        mem_d [DEPTH];
   entry_t        head_q, head_d;
   logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push_s, do_pop_s;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign do_push_s = push && (count_q != CW'(DEPTH));
   assign do_pop_s  = pop && (count_q != '0);
   assign head      = head_q;
   assign count     = count_q;

   // Pointer, occupancy and storage update; head is re-registered from the next state.
   always_comb begin
      mem_d   = mem_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      count_d = count_q;
      if (flush) begin
         rd_d    = '0;
         wr_d    = '0;
         count_d = '0;
      end else begin
         if (do_push_s) begin
            mem_d[wr_q] = push_data;
            wr_d        = ptr_inc(wr_q);
         end else begin
            wr_d = wr_q;
         end
         rd_d    = do_pop_s ? ptr_inc(rd_q) : rd_q;
         count_d = count_q + CW'(do_push_s) - CW'(do_pop_s);
      end
      head_d = mem_d[rd_d];
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q   <= '{default: '0};
         head_q  <= '0;
         rd_q    <= '0;
         wr_q    <= '0;
         count_q <= '0;
      end else begin
         mem_q   <= mem_d;
         head_q  <= head_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/fetch_redirect_unit.sv
// Fetch front end: owns the PC, issues imem requests, squashes wrong-path responses.
// Build option FETCH_MISALIGN_TRAP_EN adds misalign_err and halts on unaligned redirect targets.
module fetch_redirect_unit
   import fetch_pkg::*;
#(
   parameter int              PC_W      = 9,
   parameter logic [PC_W-1:0] RESET_PC  = '0,
   parameter int              MAX_OUTST = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            redir_valid,
   input  logic [31:0]     redir_pc,
   input  logic            halt,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [PC_W-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   output logic            if_valid,
   input  logic            if_ready,
   output logic [31:0]     if_instr,
   output logic [PC_W-1:0] if_pc,
   output logic            halted
`ifdef FETCH_MISALIGN_TRAP_EN
   ,
   output logic            misalign_err
`endif
);
   localparam int CW = $clog2(MAX_OUTST + 1);

   fetch_state_t    state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d, redir_tgt_s, tag_head_s;
   logic [CW-1:0]   drop_q, drop_d, outst_s, buf_count_s;
   fetch_entry_t    buf_push_s, buf_head_s;
   logic            fire_s, rsp_ok_s, redir_take_s, push_s, pop_s, unused_s;

   // A halted unit ignores redirects; responses with nothing in flight are ignored.
   assign redir_take_s   = (state_q == RUN) && redir_valid;
   assign rsp_ok_s       = imem_rsp_valid && (outst_s != '0);
   assign imem_req_valid = rst_n && (state_q == RUN) && !redir_valid && !halt &&
                           ((int'(outst_s) + int'(buf_count_s)) < MAX_OUTST);
   assign imem_req_addr  = pc_q;
   assign fire_s         = imem_req_valid && imem_req_ready;
   assign push_s         = rsp_ok_s && (drop_q == '0) && !redir_take_s;
   assign if_valid       = (buf_count_s != '0);
   assign pop_s          = if_valid && if_ready;
   assign buf_push_s.instr = imem_rsp_data;
   assign buf_push_s.pc    = FETCH_PC_MAX_W'(tag_head_s);
   assign if_instr       = buf_head_s.instr;
   assign if_pc          = buf_head_s.pc[PC_W-1:0];
   assign halted         = (state_q == HALTED);
   assign unused_s       = ^{buf_head_s.pc, redir_pc};

`ifdef FETCH_MISALIGN_TRAP_EN
   logic misalign_s, misalign_err_q, misalign_err_d;
   assign misalign_s   = (redir_pc[1:0] != 2'b00);
   assign redir_tgt_s  = redir_pc[PC_W-1:0];
   assign misalign_err = misalign_err_q;
`else
   assign redir_tgt_s  = {redir_pc[PC_W-1:2], 2'b00};
`endif

   // Next PC, wrong-path drop count and run/halt state; a redirect beats a same-cycle halt.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      drop_d  = drop_q;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_err_d = misalign_err_q;
`endif
      if (redir_take_s) begin
         pc_d   = redir_tgt_s;
         drop_d = outst_s - CW'(rsp_ok_s);
`ifdef FETCH_MISALIGN_TRAP_EN
         if (misalign_s) begin
            misalign_err_d = 1'b1;
            state_d        = HALTED;
         end else begin
            misalign_err_d = misalign_err_q;
         end
`endif
      end else begin
         pc_d   = fire_s ? pc_q + PC_W'(INSTR_BYTES) : pc_q;
         drop_d = (rsp_ok_s && (drop_q != '0)) ? drop_q - CW'(1) : drop_q;
         if ((state_q == RUN) && halt) begin
            state_d = HALTED;
         end else begin
            state_d = state_q;
         end
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         pc_q    <= RESET_PC;
         drop_q  <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
         misalign_err_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         drop_q  <= drop_d;
`ifdef FETCH_MISALIGN_TRAP_EN
         misalign_err_q <= misalign_err_d;
`endif
      end
   end

   // In-flight request addresses; its occupancy is the outstanding count.
   fetch_buffer #(
      .DEPTH   (MAX_OUTST),
      .entry_t (logic [PC_W-1:0]),
      .CW      (CW)
   ) u_tag_q (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (fire_s),
      .pop       (rsp_ok_s),
      .flush     (1'b0),
      .push_data (pc_q),
      .head      (tag_head_s),
      .count     (outst_s)
   );

   fetch_buffer #(
      .DEPTH   (MAX_OUTST),
      .entry_t (fetch_entry_t),
      .CW      (CW)
   ) u_out_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push_s),
      .pop       (pop_s),
      .flush     (redir_take_s),
      .push_data (buf_push_s),
      .head      (buf_head_s),
      .count     (buf_count_s)
   );

   fetch_redirect_chk #(.CW(CW)) u_chk (
      .clk       (clk),
      .rst_n     (rst_n),
      .rsp_valid (imem_rsp_valid),
      .outst     (outst_s)
   );

endmodule

// Protocol checker: the instruction memory must not answer when nothing is in flight.
module fetch_redirect_chk #(
   parameter int CW = 2
) (
   input logic          clk,
   input logic          rst_n,
   input logic          rsp_valid,
   input logic [CW-1:0] outst
);
   a_rsp_needs_outst: assert property (@(posedge clk) disable iff (!rst_n)
      rsp_valid |-> (outst != '0));
endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Self-checking bench for fetch_redirect_unit: scoreboard of issued fetches plus a redirect vector table.
module tb_fetch_redirect_unit;

   logic        clk;
   logic        rst_n;
   logic        redir_valid;
   logic [31:0] redir_pc;
   logic        halt;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [8:0]  imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instr;
   logic [8:0]  if_pc;
   logic        halted;
`ifdef FETCH_MISALIGN_TRAP_EN
   logic        misalign_err;
`endif

   fetch_redirect_unit #(.PC_W(9), .RESET_PC(9'h000), .MAX_OUTST(2)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .redir_valid    (redir_valid),
      .redir_pc       (redir_pc),
      .halt           (halt),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_instr       (if_instr),
      .if_pc          (if_pc),
      .halted         (halted)
`ifdef FETCH_MISALIGN_TRAP_EN
      ,
      .misalign_err   (misalign_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [8:0]  pc;
      logic [31:0] instr;
   } exp_t;

   typedef struct {
      logic [31:0] tgt;
      logic [8:0]  want;
   } vec_t;

   exp_t       sb[$];
   logic [8:0] rq[$];
   logic [8:0] exp_pc;
   logic       exp_halted;
   bit         rsp_hold;
   bit         fired;
   logic [8:0] fire_addr;
   int         n_checks;
   int         n_fail;
   vec_t       vecs[6];

   function automatic logic [31:0] instr_of(input logic [8:0] a);
      return 32'hC0DE_0000 | {23'h0, a};
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // One clock: observe at the falling edge, update model, then drive imem response after the rising edge.
   task automatic step();
      exp_t e;
      logic next_halted;
      @(negedge clk);
      fired       = 1'b0;
      next_halted = exp_halted;
      check("halted", {31'h0, halted}, {31'h0, exp_halted});
      if (exp_halted) check("no_req_when_halted", {31'h0, imem_req_valid}, 32'h0);
      if (if_valid && if_ready) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_delivery: got pc %0h, expected no delivery", if_pc);
         end else begin
            e = sb.pop_front();
            check("if_pc", {23'h0, if_pc}, {23'h0, e.pc});
            check("if_instr", if_instr, e.instr);
         end
      end
      if (imem_req_valid && imem_req_ready) begin
         check("req_addr", {23'h0, imem_req_addr}, {23'h0, exp_pc});
         sb.push_back('{pc: exp_pc, instr: instr_of(exp_pc)});
         rq.push_back(imem_req_addr);
         fired     = 1'b1;
         fire_addr = imem_req_addr;
         exp_pc    = exp_pc + 9'd4;
      end
      if (redir_valid && !exp_halted) begin
         sb.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
         if (redir_pc[1:0] != 2'b00) begin
            exp_pc      = redir_pc[8:0];
            next_halted = 1'b1;
         end else begin
            exp_pc = redir_pc[8:0];
         end
`else
         exp_pc = redir_pc[8:0] & 9'h1FC;
`endif
      end else if (halt && !exp_halted) begin
         next_halted = 1'b1;
      end
      @(posedge clk);
      #1;
      exp_halted = next_halted;
      if (!rsp_hold && rq.size() > 0) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = instr_of(rq.pop_front());
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = 32'h0;
      end
   endtask

   task automatic steps(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic wait_fire(input string nm, input logic [8:0] want);
      bit got;
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
         step();
         got = fired;
      end
      if (!got) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: no request issued, expected addr %0h", nm, want);
      end else begin
         check(nm, {23'h0, fire_addr}, {23'h0, want});
      end
   endtask

   // Assert reset at a quiet point, check outputs clear at once, release after the next rising edge.
   task automatic do_reset();
      rst_n          = 1'b0;
      redir_valid    = 1'b0;
      halt           = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      sb.delete();
      rq.delete();
      exp_pc     = 9'h000;
      exp_halted = 1'b0;
      rsp_hold   = 1'b0;
      #1;
      check("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
      check("rst_if_valid", {31'h0, if_valid}, 32'h0);
      check("rst_if_instr", if_instr, 32'h0);
      check("rst_if_pc", {23'h0, if_pc}, 32'h0);
      check("rst_halted", {31'h0, halted}, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
      check("rst_misalign_err", {31'h0, misalign_err}, 32'h0);
`endif
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      bit seen;
      n_checks = 0;
      n_fail   = 0;
      vecs[0] = '{tgt: 32'h0000_0040, want: 9'h040};
      vecs[1] = '{tgt: 32'h0000_01FC, want: 9'h1FC};
      vecs[2] = '{tgt: 32'hFFFF_FE10, want: 9'h010};
      vecs[3] = '{tgt: 32'h0000_0000, want: 9'h000};
`ifdef FETCH_MISALIGN_TRAP_EN
      vecs[4] = '{tgt: 32'h0000_0100, want: 9'h100};
      vecs[5] = '{tgt: 32'h0000_008C, want: 9'h08C};
`else
      vecs[4] = '{tgt: 32'h0000_0042, want: 9'h040};
      vecs[5] = '{tgt: 32'h0000_013B, want: 9'h138};
`endif
      rst_n          = 1'b1;
      redir_valid    = 1'b0;
      redir_pc       = 32'h0;
      halt           = 1'b0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      if_ready       = 1'b0;
      rsp_hold       = 1'b0;
      #2;
      do_reset();

      // Sequential fetch: request in cycle 0, response in cycle 1, decode sees it in cycle 2.
      imem_req_ready = 1'b1;
      if_ready       = 1'b1;
      for (int i = 0; i < 14; i++) begin
         if (i < 3) check("first_valid_timing", {31'h0, if_valid}, {31'h0, (i == 2)});
         step();
      end

      // Backpressure: decode stalls, issue must stop at the buffer/outstanding limit.
      if_ready = 1'b0;
      cnt      = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (fired) cnt++;
      end
      check("bp_fires_le_max", {31'h0, (cnt <= 2)}, 32'h1);
      check("bp_req_stalled", {31'h0, imem_req_valid}, 32'h0);
      if_ready = 1'b1;
      steps(10);

      // Redirect while two requests are in flight: both responses must be dropped.
      imem_req_ready = 1'b0;
      steps(6);
      check("drained_before_redirect", sb.size(), 32'h0);
      rsp_hold       = 1'b1;
      imem_req_ready = 1'b1;
      steps(2);
      check("two_outstanding_stall", {31'h0, imem_req_valid}, 32'h0);
      redir_valid = 1'b1;
      redir_pc    = 32'h0000_0040;
      step();
      redir_valid = 1'b0;
      rsp_hold    = 1'b0;
      seen        = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         if (if_valid) seen = 1'b1;
         else step();
      end
      if (!seen) begin
         n_checks++;
         n_fail++;
         $display("FAIL first_pc_after_redirect: if_valid never rose, expected pc 40");
      end else begin
         check("first_pc_after_redirect", {23'h0, if_pc}, 32'h40);
      end
      steps(4);

      // Redirect target table: the first request after each redirect must use the listed address.
      for (int v = 0; v < 6; v++) begin
         redir_valid = 1'b1;
         redir_pc    = vecs[v].tgt;
         step();
         redir_valid = 1'b0;
         wait_fire("vec_redirect_addr", vecs[v].want);
         steps(3);
      end

      // Reset in the middle of operation with two requests outstanding.
      rsp_hold = 1'b1;
      steps(3);
      do_reset();
      imem_req_ready = 1'b1;
      if_ready       = 1'b1;
      wait_fire("addr_after_reset", 9'h000);
      steps(8);

      // Redirect, response and halt in the same cycle: redirect wins, response is discarded.
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
         if (imem_rsp_valid) seen = 1'b1;
         else step();
      end
      check("rsp_before_redirect_halt", {31'h0, seen}, 32'h1);
      redir_valid = 1'b1;
      redir_pc    = 32'h0000_0080;
      halt        = 1'b1;
      step();
      redir_valid = 1'b0;
      halt        = 1'b0;
      check("halted_after_redirect_halt", {31'h0, halted}, 32'h0);
      wait_fire("addr_after_redirect_halt", 9'h080);

      // Later halt with entries pending: no further requests, buffer still drains.
      if_ready = 1'b0;
      steps(4);
      halt = 1'b1;
      step();
      halt = 1'b0;
      check("halted_set", {31'h0, halted}, 32'h1);
      if_ready = 1'b1;
      steps(8);
      check("halt_drained", sb.size(), 32'h0);
      check("halted_sticky", {31'h0, halted}, 32'h1);

      // Misaligned redirect target.
      do_reset();
      imem_req_ready = 1'b1;
      redir_valid    = 1'b1;
      redir_pc       = 32'h0000_0042;
      step();
      redir_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      check("misalign_err_set", {31'h0, misalign_err}, 32'h1);
      check("misalign_halted", {31'h0, halted}, 32'h1);
      steps(3);
`else
      wait_fire("misalign_cleared_addr", 9'h040);
      steps(3);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
